fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among NREQ requesters
module fifo_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4,
  localparam int GNT_W     = $clog2(NREQ),
  localparam int CNT_W     = $clog2(BURST_MAX) + 1
) (
  input  logic                       wclk,
  input  logic                       wrst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]            req_last,
  output logic [NREQ-1:0]            ack,
  input  logic                       full,
  output logic                       fifo_wen,
  output logic [DATA_WIDTH-1:0]      fifo_wdata,
  output logic                       grant_valid,
  output logic [GNT_W-1:0]           grant_id
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_MAX - 1);
  localparam logic [GNT_W-1:0] TOP_GNT  = GNT_W'(NREQ - 1);

  state_t           state_q, state_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [GNT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             found;
  logic [GNT_W-1:0] pick;
  logic             req_gnt;
  logic             last_gnt;
  logic [GNT_W-1:0] gnt_next;

  // Register the FSM state, grant, priority pointer and beat count.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Round-robin search: first set request at or after rr_ptr, wrapping modulo NREQ.
  // Scanning from the far end down lets the nearest hit win without a break.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        found = 1'b1;
        pick  = GNT_W'(idx);
      end
    end
  end

  // Per-granted-requester views of req and req_last, plus the successor index.
  always_comb begin
    req_gnt  = 1'b0;
    last_gnt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q == GNT_W'(i)) begin
        req_gnt  = req[i];
        last_gnt = req_last[i];
      end
    end
    gnt_next = (gnt_q == TOP_GNT) ? '0 : gnt_q + 1'b1;
  end

  // Next-state: arbitrate in IDLE; in XFER count beats and release on last, burst limit or withdrawal.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = XFER;
          gnt_d      = pick;
          beat_cnt_d = '0;
        end
      end
      XFER: begin
        if (!req_gnt) begin
          state_d  = IDLE;
          rr_ptr_d = gnt_next;
        end else if (fifo_wen) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_gnt || (beat_cnt_q == LAST_CNT)) begin
            state_d  = IDLE;
            rr_ptr_d = gnt_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: writes only in XFER, gated by full locally so overflow never depends on the FIFO.
  always_comb begin
    grant_valid = (state_q == XFER);
    grant_id    = grant_valid ? gnt_q : '0;
    fifo_wen    = grant_valid & req_gnt & ~full;
    ack         = '0;
    fifo_wdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_valid && (gnt_q == GNT_W'(i))) begin
        ack[i]     = fifo_wen;
        fifo_wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int BMAX = 4;
  localparam int GW   = $clog2(NREQ);

  logic               wclk = 1'b0;
  logic               wrst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    ack;
  logic               full;
  logic               fifo_wen;
  logic [DW-1:0]      fifo_wdata;
  logic               grant_valid;
  logic [GW-1:0]      grant_id;

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .BURST_MAX(BMAX)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .full(full), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // behavioural model: which requester holds the grant (-1 = none), beats served, next priority
  int m_gnt   = -1;
  int m_beats = 0;
  int m_rr    = 0;

  int            log_id[$];
  int            log_data[$];
  int            log_cyc[$];
  logic [NREQ-1:0] ack_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // per-cycle comparison of every output against the model, then advance the model
  always @(negedge wclk) begin
    logic            e_gv;
    logic [GW-1:0]   e_gid;
    logic            e_wen;
    logic [NREQ-1:0] e_ack;
    logic [DW-1:0]   e_data;
    if (!wrst_n) begin
      m_gnt = -1; m_beats = 0; m_rr = 0;
    end
    e_gv = (m_gnt >= 0); e_gid = '0; e_wen = 1'b0; e_ack = '0; e_data = '0;
    if (e_gv) begin
      e_gid  = GW'(m_gnt);
      e_wen  = req[m_gnt] && !full;
      e_data = req_data[m_gnt*DW +: DW];
      if (e_wen) e_ack = NREQ'(1) << m_gnt;
    end
    chk("grant_valid", 64'(grant_valid), 64'(e_gv));
    chk("grant_id",    64'(grant_id),    64'(e_gid));
    chk("fifo_wen",    64'(fifo_wen),    64'(e_wen));
    chk("ack",         64'(ack),         64'(e_ack));
    chk("fifo_wdata",  64'(fifo_wdata),  64'(e_data));
    if (full) chk("no_write_while_full", 64'(fifo_wen), 64'(0));
    ack_seen = ack;
    if (fifo_wen) begin
      for (int i = 0; i < NREQ; i++) if (ack[i]) log_id.push_back(i);
      log_data.push_back(int'(fifo_wdata));
      log_cyc.push_back(cyc);
    end
    if (wrst_n) begin
      if (m_gnt < 0) begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (req[(m_rr + k) % NREQ]) begin m_gnt = (m_rr + k) % NREQ; m_beats = 0; end
      end else if (!req[m_gnt]) begin
        m_rr = (m_gnt + 1) % NREQ; m_gnt = -1;
      end else if (!full) begin
        m_beats++;
        if (req_last[m_gnt] || m_beats == BMAX) begin m_rr = (m_gnt + 1) % NREQ; m_gnt = -1; end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic apply_reset();
    wrst_n = 1'b0; req = '0; req_last = '0; full = 1'b0; req_data = '0;
    step(); step();
    wrst_n = 1'b1;
  endtask

  int t0, t1, base;

  initial begin
    // 1. reset held with all requests pending
    wrst_n = 1'b0; req = 4'b1111; req_last = '0; full = 1'b0; req_data = 32'h44332211;
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      chk("rst_wen", 64'(fifo_wen), 64'(0));
      chk("rst_ack", 64'(ack), 64'(0));
      chk("rst_gv",  64'(grant_valid), 64'(0));
      chk("rst_gid", 64'(grant_id), 64'(0));
    end

    // 2. single burst from requester 2
    apply_reset();
    base = log_id.size(); t0 = cyc;
    req = 4'b0100; req_data[2*DW +: DW] = 8'hA1;
    step();
    step(); req_data[2*DW +: DW] = 8'hA2;
    step(); req_data[2*DW +: DW] = 8'hA3; req_last = 4'b0100;
    step(); req = '0; req_last = '0; #2;
    chk("t2_idle_after", 64'(grant_valid), 64'(0));
    chk("t2_nbeats", 64'(log_id.size() - base), 64'(3));
    if (log_id.size() - base == 3) begin
      chk("t2_latency", 64'(log_cyc[base]), 64'(t0 + 1));
      chk("t2_d0", 64'(log_data[base]),     64'h A1);
      chk("t2_d1", 64'(log_data[base + 1]), 64'h A2);
      chk("t2_d2", 64'(log_data[base + 2]), 64'h A3);
      chk("t2_id", 64'(log_id[base + 2]),   64'(2));
    end

    // 3. round robin under continuous request
    apply_reset();
    base = log_id.size(); t0 = cyc;
    req = 4'b1111; req_data = 32'h40302010;
    repeat (25) step();
    req = '0;
    repeat (3) step();
    chk("t3_enough_beats", 64'(log_id.size() - base >= 20), 64'(1));
    if (log_id.size() - base >= 20)
      for (int j = 0; j < 20; j++) begin
        chk("t3_order", 64'(log_id[base + j]), 64'((j / 4) % 4));
        chk("t3_cycle", 64'(log_cyc[base + j]), 64'(t0 + 1 + j + j / 4));
      end

    // 4. full stall mid-burst for requester 1
    apply_reset();
    base = log_id.size(); t0 = cyc;
    req = 4'b0010; req_data = 32'h00005500;
    step(); step(); step();
    full = 1'b1; #2;
    chk("t4_stall_gid", 64'(grant_id), 64'(1));
    chk("t4_stall_wen", 64'(fifo_wen), 64'(0));
    step(); step(); step();
    full = 1'b0;
    step(); step();
    req = '0;
    step();
    chk("t4_nbeats", 64'(log_id.size() - base), 64'(4));
    if (log_id.size() - base == 4) begin
      chk("t4_c0", 64'(log_cyc[base]),     64'(t0 + 1));
      chk("t4_c1", 64'(log_cyc[base + 1]), 64'(t0 + 2));
      chk("t4_c2", 64'(log_cyc[base + 2]), 64'(t0 + 6));
      chk("t4_c3", 64'(log_cyc[base + 3]), 64'(t0 + 7));
    end

    // 5. withdrawal then search from rr_ptr=1 finds requester 3
    apply_reset();
    base = log_id.size(); t0 = cyc;
    req = 4'b1001; req_last = 4'b1000; req_data = 32'h33000011;
    step(); step();
    req = 4'b1000;
    step(); step(); step();
    req = '0; req_last = '0;
    step();
    chk("t5_nbeats", 64'(log_id.size() - base), 64'(2));
    if (log_id.size() - base == 2) begin
      chk("t5_first",  64'(log_id[base]),      64'(0));
      chk("t5_second", 64'(log_id[base + 1]),  64'(3));
      chk("t5_cyc2",   64'(log_cyc[base + 1]), 64'(t0 + 4));
    end

    // 6. asynchronous reset during requester 2's second beat
    apply_reset();
    base = log_id.size();
    req = 4'b0100; req_data = 32'h00770000;
    step(); step();
    #2 wrst_n = 1'b0;
    #1;
    chk("t6_wen_drop", 64'(fifo_wen), 64'(0));
    chk("t6_ack_drop", 64'(ack), 64'(0));
    step();
    chk("t6_beats_before", 64'(log_id.size() - base), 64'(1));
    wrst_n = 1'b1; req = 4'b0101; req_data = 32'h00BB00AA;
    base = log_id.size(); t1 = cyc;
    step(); step(); step();
    req = '0;
    repeat (4) step();
    chk("t6_some_beats", 64'(log_id.size() > base), 64'(1));
    if (log_id.size() > base) begin
      chk("t6_first_id",  64'(log_id[base]),  64'(0));
      chk("t6_first_cyc", 64'(log_cyc[base]), 64'(t1 + 1));
    end

    // randomized traffic against the model
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (ack_seen[i]) begin
            req_data[i*DW +: DW] = DW'($urandom);
            req_last[i] = ($urandom % 4 == 0);
            if ($urandom % 4 == 0) req[i] = 1'b0;
          end else if ($urandom % 32 == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom % 3 == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
          req_last[i] = ($urandom % 4 == 0);
        end
      end
      full = ($urandom % 4 == 0);
      step();
    end
    req = '0; full = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
